mem_lsu: RTL and testbench
==========================

Name: mem_lsu

Overview:
- Parametrised load/store unit for the MEM stage. It replaces the single-cycle RAM access path with a multi-cycle, handshaked data-bus master.
- Accepts one memory op at a time from EX/MEM and generates byte-enables and replicated store data for a DATA_W-wide bus.
- Detects misaligned addresses (AdEL/AdES), holds the pipeline via stall_o while the bus transaction is in flight, and extracts and sign/zero-extends load data.
- Survives an exception flush mid-transaction by draining, then discarding, the outstanding response.

Parameters:
- ADDR_W, 32, address width of addr_i / data_addr_o.
- DATA_W, 32, data bus width; legal values are 32 and 64. Byte-enable width is DATA_W/8.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-low (0 = reset).
- valid_i  in  1  a memory op is present in MEM.
- op_i  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- addr_i  in  ADDR_W  effective address.
- wdata_i  in  32  store source register.
- flush_i  in  1  exception/ERET flush from CP0; kills the current op.
- stall_o  out  1  hold IF..MEM.
- done_o  out  1  op completed this cycle; result_o valid.
- result_o  out  32  extended load data (0 for stores).
- exc_adel_o  out  1  misaligned load.
- exc_ades_o  out  1  misaligned store.
- badvaddr_o  out  ADDR_W  faulting address (equals addr_i when exc_* = 1, else 0).
- data_req_o  out  1  bus request.
- data_wr_o  out  1  1 = store.
- data_be_o  out  DATA_W/8  byte enables.
- data_addr_o  out  ADDR_W  bus address, low log2(DATA_W/8) bits forced to 0.
- data_wdata_o  out  DATA_W  store data.
- data_addr_ok_i  in  1  request accepted.
- data_rdata_i  in  DATA_W  read data.
- data_data_ok_i  in  1  response (read data or write ack).

Behaviour:
- Reset (rst_i = 0 at an edge):
  - state goes to IDLE.
  - data_req_o, data_wr_o, data_be_o, data_addr_o, data_wdata_o and the internal op/lane registers all go to 0.
  - Combinational outputs are therefore 0 after reset.
  - Reset mid-transaction abandons it; the bus slave is reset together with this block.
- Alignment:
  - Halfword ops are misaligned if addr_i[0] = 1.
  - Word ops are misaligned if addr_i[1:0] != 0.
  - In IDLE with valid_i = 1 and misaligned: exc_adel_o (loads) or exc_ades_o (stores) = 1 and badvaddr_o = addr_i, both combinational in the same cycle. No bus request is made; stall_o = 0 and done_o = 0.
- Accept: in IDLE with valid_i = 1, aligned, and flush_i = 0. On the edge the block registers the op, byte offset and lane, and moves to REQ.
- Lane (DATA_W = 64): lane = addr_i[2]. Byte enables and extraction are offset by 4*lane. For DATA_W = 32, lane = 0.
- Byte enables (within the 32-bit lane):
  - SB/LB/LBU: 1 << addr[1:0].
  - SH/LH/LHU: 0011 << addr[1:0].
  - SW/LW: 1111.
- Store data: wdata_i placement by op:
  - SB: wdata_i[7:0] replicated 4 times.
  - SH: wdata_i[15:0] replicated 2 times.
  - SW: wdata_i as is.
  - The resulting 32-bit word is replicated across both 32-bit lanes when DATA_W = 64.
- FSM:
  - IDLE: on accept, go to REQ.
  - REQ: data_req_o = 1 with registered addr/be/wr/wdata held stable. When data_addr_ok_i = 1, go to WAIT. If flush_i = 1 was seen in IDLE-accept or REQ, the kill flag is set and the request is still held until addr_ok (no retraction).
  - WAIT: data_req_o = 0. When data_data_ok_i = 1: if kill = 0, done_o = 1 for that cycle. In either case go to IDLE and clear kill. flush_i in WAIT sets kill.
  - The slave never asserts data_ok in the same cycle as addr_ok; the bench's slave model must respect this.
- result_o (on done_o, loads only), taken from the selected lane byte/half at the registered offset:
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - LW: full word.
  - Stores: 0.
- stall_o = (valid_i & accept-condition) | (state != IDLE & !done_o). With kill set, stall_o = 0, since the pipeline is being flushed. A new op is not accepted until IDLE.
- Minimum latency: accept in cycle 0, addr_ok in cycle 1, data_ok and done_o in cycle 2. Each extra slave wait cycle adds 1.

Test Plan:
- DATA_W = 32, LB at addr 0x1003; slave returns 0x80_11_22_33 with addr_ok in cycle 1 and data_ok in cycle 2.
  -> data_be_o = 1000 and data_addr_o = 0x1000.
  -> done_o in cycle 2 with result_o = 0xFFFFFF80.
  -> stall_o = 1 in cycles 0–1 and 0 in cycle 2.
- DATA_W = 64, SH at addr 0x2006 with wdata_i = 0x0000ABCD.
  -> data_be_o = 0xC0, data_addr_o = 0x2000, data_wdata_o = 0xABCDABCD_ABCDABCD, data_wr_o = 1.
  -> done_o on data_ok with result_o = 0.
- LW at addr 0x1002.
  -> exc_adel_o = 1 and badvaddr_o = 0x1002 in the same cycle.
  -> No data_req_o, stall_o = 0, FSM stays in IDLE.
- LHU at addr 0x3002, slave stalls addr_ok for 3 cycles, flush_i pulsed during REQ.
  -> data_req_o held until addr_ok.
  -> data_ok is consumed with done_o = 0 and the block returns to IDLE.
  -> A following LW is accepted only after that.
- rst_i = 0 asserted while in WAIT.
  -> Next cycle state is IDLE and data_req_o, done_o and stall_o are all 0.
  -> A following data_data_ok_i is ignored.
- Back-to-back SW then LBU (addr 0x10, rdata 0x000000F0).
  -> Second accept happens only after the first done_o.
  -> result_o = 0x000000F0.

Source files
------------

// File: rtl/mem_lsu_if.sv
// Data-bus interface between the load/store unit (master) and the memory slave.
interface mem_lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  data_req;
    logic                  data_wr;
    logic [DATA_W/8-1:0]   data_be;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_addr_ok;
    logic [DATA_W-1:0]     data_rdata;
    logic                  data_data_ok;

    modport master (
        output data_req, data_wr, data_be, data_addr, data_wdata,
        input  data_addr_ok, data_rdata, data_data_ok
    );

    modport slave (
        input  data_req, data_wr, data_be, data_addr, data_wdata,
        output data_addr_ok, data_rdata, data_data_ok
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: a multi-cycle handshaked data-bus master that
// checks alignment, builds byte enables and store data, holds the pipeline
// while a transaction is in flight and extends returned load data.
module mem_lsu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [2:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [31:0]       result_o,
    output logic              exc_adel_o,
    output logic              exc_ades_o,
    output logic [ADDR_W-1:0] badvaddr_o,
    mem_lsu_if.master         bus
);

    localparam int LANES = DATA_W / 32;
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic        lane_q;
    logic        kill;

    logic             is_store;
    logic [1:0]       size;
    logic             misaligned;
    logic             accept;
    logic             done;
    logic             lane;
    logic [3:0]       be4;
    logic [BE_W-1:0]  be_full;
    logic [31:0]      store_word;
    logic [31:0]      lane_word;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [31:0]      load_val;

    assign is_store = (op_i == 3'b101) || (op_i == 3'b110) || (op_i == 3'b111);

    // Access size from the opcode: 0 = byte, 1 = halfword, 2 = word.
    always_comb begin
        size = 2'd2;
        case (op_i)
            3'b000, 3'b001, 3'b101: size = 2'd0;
            3'b010, 3'b011, 3'b110: size = 2'd1;
            default:                size = 2'd2;
        endcase
    end

    assign misaligned = ((size == 2'd1) && addr_i[0]) ||
                        ((size == 2'd2) && (addr_i[1:0] != 2'b00));
    assign accept     = (state == S_IDLE) && valid_i && !misaligned && !flush_i;
    assign done       = (state == S_WAIT) && bus.data_data_ok && !kill;
    assign lane       = (LANES == 2) ? addr_i[2] : 1'b0;

    // Byte enables within the 32-bit lane, then placed into the selected lane.
    always_comb begin
        be4 = 4'b1111;
        case (size)
            2'd0:    be4 = 4'b0001 << addr_i[1:0];
            2'd1:    be4 = 4'b0011 << addr_i[1:0];
            default: be4 = 4'b1111;
        endcase
        be_full = '0;
        for (int l = 0; l < LANES; l++) begin
            if (int'(lane) == l) be_full[4*l +: 4] = be4;
        end
    end

    // Store data replicated so the slave finds it under whichever byte lane is enabled.
    always_comb begin
        store_word = wdata_i;
        case (size)
            2'd0:    store_word = {4{wdata_i[7:0]}};
            2'd1:    store_word = {2{wdata_i[15:0]}};
            default: store_word = wdata_i;
        endcase
    end

    // Load extraction and extension from the registered lane and byte offset.
    always_comb begin
        lane_word = bus.data_rdata[31:0];
        for (int l = 0; l < LANES; l++) begin
            if (int'(lane_q) == l) lane_word = bus.data_rdata[32*l +: 32];
        end
        load_byte = lane_word[7:0];
        case (off_q)
            2'd0:    load_byte = lane_word[7:0];
            2'd1:    load_byte = lane_word[15:8];
            2'd2:    load_byte = lane_word[23:16];
            default: load_byte = lane_word[31:24];
        endcase
        load_half = off_q[1] ? lane_word[31:16] : lane_word[15:0];
        load_val  = 32'd0;
        case (op_q)
            3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_val = {24'd0, load_byte};
            3'b010:  load_val = {{16{load_half[15]}}, load_half};
            3'b011:  load_val = {16'd0, load_half};
            3'b100:  load_val = lane_word;
            default: load_val = 32'd0;
        endcase
    end

    assign done_o     = done;
    assign result_o   = done ? load_val : 32'd0;
    assign stall_o    = accept || ((state != S_IDLE) && !done && !kill);
    assign exc_adel_o = (state == S_IDLE) && valid_i && misaligned && !is_store;
    assign exc_ades_o = (state == S_IDLE) && valid_i && misaligned && is_store;
    assign badvaddr_o = (exc_adel_o || exc_ades_o) ? addr_i : '0;

    // Transaction FSM with registered bus outputs; a flush only marks the op as killed
    // so the request is never retracted and the response is drained before going idle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state          <= S_IDLE;
            op_q           <= 3'd0;
            off_q          <= 2'd0;
            lane_q         <= 1'b0;
            kill           <= 1'b0;
            bus.data_req   <= 1'b0;
            bus.data_wr    <= 1'b0;
            bus.data_be    <= '0;
            bus.data_addr  <= '0;
            bus.data_wdata <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state          <= S_REQ;
                        op_q           <= op_i;
                        off_q          <= addr_i[1:0];
                        lane_q         <= lane;
                        kill           <= 1'b0;
                        bus.data_req   <= 1'b1;
                        bus.data_wr    <= is_store;
                        bus.data_be    <= be_full;
                        bus.data_addr  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        bus.data_wdata <= {LANES{store_word}};
                    end
                end
                S_REQ: begin
                    if (flush_i) kill <= 1'b1;
                    if (bus.data_addr_ok) begin
                        bus.data_req <= 1'b0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.data_data_ok) begin
                        state <= S_IDLE;
                        kill  <= 1'b0;
                    end else if (flush_i) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu: one 32-bit and one 64-bit bus instance.
module tb_mem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid32 = 1'b0;
    logic        valid64 = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        flush = 1'b0;

    logic        stall32, done32, adel32, ades32;
    logic [31:0] result32, bad32;
    logic        stall64, done64, adel64, ades64;
    logic [31:0] result64, bad64;

    int checks = 0;
    int failures = 0;

    mem_lsu_if #(.ADDR_W(32), .DATA_W(32)) bus32 ();
    mem_lsu_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();

    mem_lsu #(.ADDR_W(32), .DATA_W(32)) dut32 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid32), .op_i(op), .addr_i(addr),
        .wdata_i(wdata), .flush_i(flush), .stall_o(stall32), .done_o(done32),
        .result_o(result32), .exc_adel_o(adel32), .exc_ades_o(ades32),
        .badvaddr_o(bad32), .bus(bus32)
    );

    mem_lsu #(.ADDR_W(32), .DATA_W(64)) dut64 (
        .clk_i(clk), .rst_i(rst), .valid_i(valid64), .op_i(op), .addr_i(addr),
        .wdata_i(wdata), .flush_i(flush), .stall_o(stall64), .done_o(done64),
        .result_o(result64), .exc_adel_o(adel64), .exc_ades_o(ades64),
        .badvaddr_o(bad64), .bus(bus64)
    );

    always #5 clk = ~clk;

    // Advance one clock and return to the falling edge for the next stimulus.
    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        #1;
        checks++; if (bus32.data_req !== 1'b0) begin failures++; $display("[TB] FAIL rst_req32: got %b expected 0", bus32.data_req); end
        checks++; if (bus64.data_be !== 8'h00) begin failures++; $display("[TB] FAIL rst_be64: got %h expected 00", bus64.data_be); end
        checks++; if (bus64.data_wdata !== 64'd0) begin failures++; $display("[TB] FAIL rst_wdata64: got %h expected 0", bus64.data_wdata); end
        checks++; if (bus32.data_addr !== 32'd0) begin failures++; $display("[TB] FAIL rst_addr32: got %h expected 0", bus32.data_addr); end
        checks++; if ({stall32, done32, stall64, done64} !== 4'b0000) begin failures++; $display("[TB] FAIL rst_stall_done: got %b expected 0000", {stall32, done32, stall64, done64}); end
        checks++; if (result32 !== 32'd0) begin failures++; $display("[TB] FAIL rst_result32: got %h expected 0", result32); end
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_lb_sign();
        valid32 = 1'b1; op = 3'b000; addr = 32'h0000_1003;
        #1;
        checks++; if (stall32 !== 1'b1) begin failures++; $display("[TB] FAIL lb_stall_c0: got %b expected 1", stall32); end
        next_cycle();
        valid32 = 1'b0; bus32.data_addr_ok = 1'b1;
        #1;
        checks++; if (bus32.data_req !== 1'b1) begin failures++; $display("[TB] FAIL lb_req: got %b expected 1", bus32.data_req); end
        checks++; if (bus32.data_be !== 4'b1000) begin failures++; $display("[TB] FAIL lb_be: got %b expected 1000", bus32.data_be); end
        checks++; if (bus32.data_addr !== 32'h0000_1000) begin failures++; $display("[TB] FAIL lb_addr: got %h expected 00001000", bus32.data_addr); end
        checks++; if (bus32.data_wr !== 1'b0) begin failures++; $display("[TB] FAIL lb_wr: got %b expected 0", bus32.data_wr); end
        checks++; if (stall32 !== 1'b1) begin failures++; $display("[TB] FAIL lb_stall_c1: got %b expected 1", stall32); end
        next_cycle();
        bus32.data_addr_ok = 1'b0; bus32.data_data_ok = 1'b1; bus32.data_rdata = 32'h8011_2233;
        #1;
        checks++; if (bus32.data_req !== 1'b0) begin failures++; $display("[TB] FAIL lb_req_c2: got %b expected 0", bus32.data_req); end
        checks++; if (done32 !== 1'b1) begin failures++; $display("[TB] FAIL lb_done: got %b expected 1", done32); end
        checks++; if (result32 !== 32'hFFFF_FF80) begin failures++; $display("[TB] FAIL lb_result: got %h expected ffffff80", result32); end
        checks++; if (stall32 !== 1'b0) begin failures++; $display("[TB] FAIL lb_stall_c2: got %b expected 0", stall32); end
        next_cycle();
        bus32.data_data_ok = 1'b0;
        #1;
        checks++; if ({done32, stall32} !== 2'b00) begin failures++; $display("[TB] FAIL lb_idle_after: got %b expected 00", {done32, stall32}); end
        next_cycle();
    endtask

    task automatic test_sh_lane64();
        valid64 = 1'b1; op = 3'b110; addr = 32'h0000_2006; wdata = 32'h0000_ABCD;
        #1;
        checks++; if (stall64 !== 1'b1) begin failures++; $display("[TB] FAIL sh_stall_c0: got %b expected 1", stall64); end
        next_cycle();
        valid64 = 1'b0; bus64.data_addr_ok = 1'b1;
        #1;
        checks++; if (bus64.data_be !== 8'hC0) begin failures++; $display("[TB] FAIL sh_be: got %h expected c0", bus64.data_be); end
        checks++; if (bus64.data_addr !== 32'h0000_2000) begin failures++; $display("[TB] FAIL sh_addr: got %h expected 00002000", bus64.data_addr); end
        checks++; if (bus64.data_wdata !== 64'hABCDABCD_ABCDABCD) begin failures++; $display("[TB] FAIL sh_wdata: got %h expected abcdabcdabcdabcd", bus64.data_wdata); end
        checks++; if ({bus64.data_req, bus64.data_wr} !== 2'b11) begin failures++; $display("[TB] FAIL sh_req_wr: got %b expected 11", {bus64.data_req, bus64.data_wr}); end
        next_cycle();
        bus64.data_addr_ok = 1'b0; bus64.data_data_ok = 1'b1; bus64.data_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checks++; if (done64 !== 1'b1) begin failures++; $display("[TB] FAIL sh_done: got %b expected 1", done64); end
        checks++; if (result64 !== 32'd0) begin failures++; $display("[TB] FAIL sh_result: got %h expected 0", result64); end
        next_cycle();
        bus64.data_data_ok = 1'b0;
        next_cycle();
    endtask

    task automatic test_misaligned();
        valid32 = 1'b1; op = 3'b100; addr = 32'h0000_1002;
        #1;
        checks++; if ({adel32, ades32} !== 2'b10) begin failures++; $display("[TB] FAIL adel_flags: got %b expected 10", {adel32, ades32}); end
        checks++; if (bad32 !== 32'h0000_1002) begin failures++; $display("[TB] FAIL adel_badv: got %h expected 00001002", bad32); end
        checks++; if ({stall32, done32} !== 2'b00) begin failures++; $display("[TB] FAIL adel_stall_done: got %b expected 00", {stall32, done32}); end
        next_cycle();
        valid32 = 1'b0;
        #1;
        checks++; if ({bus32.data_req, stall32} !== 2'b00) begin failures++; $display("[TB] FAIL adel_no_req: got %b expected 00", {bus32.data_req, stall32}); end
        checks++; if (bad32 !== 32'd0) begin failures++; $display("[TB] FAIL badv_clear: got %h expected 0", bad32); end
        valid64 = 1'b1; op = 3'b110; addr = 32'h0000_2005;
        #1;
        checks++; if ({adel64, ades64} !== 2'b01) begin failures++; $display("[TB] FAIL ades_flags: got %b expected 01", {adel64, ades64}); end
        checks++; if (bad64 !== 32'h0000_2005) begin failures++; $display("[TB] FAIL ades_badv: got %h expected 00002005", bad64); end
        next_cycle();
        valid64 = 1'b0;
        #1;
        checks++; if (bus64.data_req !== 1'b0) begin failures++; $display("[TB] FAIL ades_no_req: got %b expected 0", bus64.data_req); end
        next_cycle();
    endtask

    task automatic test_flush_drain();
        valid32 = 1'b1; op = 3'b011; addr = 32'h0000_3002;
        next_cycle();
        valid32 = 1'b0; flush = 1'b1;
        #1;
        checks++; if ({bus32.data_req, stall32} !== 2'b11) begin failures++; $display("[TB] FAIL fl_req_c1: got %b expected 11", {bus32.data_req, stall32}); end
        next_cycle();
        flush = 1'b0;
        #1;
        checks++; if ({bus32.data_req, stall32} !== 2'b10) begin failures++; $display("[TB] FAIL fl_req_killed: got %b expected 10", {bus32.data_req, stall32}); end
        next_cycle();
        #1;
        checks++; if (bus32.data_req !== 1'b1) begin failures++; $display("[TB] FAIL fl_req_c3: got %b expected 1", bus32.data_req); end
        next_cycle();
        bus32.data_addr_ok = 1'b1;
        next_cycle();
        bus32.data_addr_ok = 1'b0; bus32.data_data_ok = 1'b1; bus32.data_rdata = 32'h5555_AAAA;
        valid32 = 1'b1; op = 3'b100; addr = 32'h0000_4000;
        #1;
        checks++; if ({done32, bus32.data_req, stall32} !== 3'b000) begin failures++; $display("[TB] FAIL fl_drain: got %b expected 000", {done32, bus32.data_req, stall32}); end
        next_cycle();
        bus32.data_data_ok = 1'b0;
        #1;
        checks++; if ({stall32, bus32.data_req} !== 2'b10) begin failures++; $display("[TB] FAIL fl_lw_accept: got %b expected 10", {stall32, bus32.data_req}); end
        next_cycle();
        valid32 = 1'b0; bus32.data_addr_ok = 1'b1;
        #1;
        checks++; if (bus32.data_addr !== 32'h0000_4000) begin failures++; $display("[TB] FAIL fl_lw_addr: got %h expected 00004000", bus32.data_addr); end
        checks++; if (bus32.data_be !== 4'b1111) begin failures++; $display("[TB] FAIL fl_lw_be: got %b expected 1111", bus32.data_be); end
        next_cycle();
        bus32.data_addr_ok = 1'b0; bus32.data_data_ok = 1'b1; bus32.data_rdata = 32'h1234_5678;
        #1;
        checks++; if ({done32, result32} !== {1'b1, 32'h1234_5678}) begin failures++; $display("[TB] FAIL fl_lw_result: got %b/%h expected 1/12345678", done32, result32); end
        next_cycle();
        bus32.data_data_ok = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_in_wait();
        valid64 = 1'b1; op = 3'b100; addr = 32'h0000_0008;
        next_cycle();
        valid64 = 1'b0; bus64.data_addr_ok = 1'b1;
        next_cycle();
        bus64.data_addr_ok = 1'b0; rst = 1'b0;
        next_cycle();
        rst = 1'b1; bus64.data_data_ok = 1'b1; bus64.data_rdata = 64'h1111_2222_3333_4444;
        #1;
        checks++; if ({bus64.data_req, done64, stall64} !== 3'b000) begin failures++; $display("[TB] FAIL rw_idle: got %b expected 000", {bus64.data_req, done64, stall64}); end
        next_cycle();
        bus64.data_data_ok = 1'b0;
        #1;
        checks++; if ({bus64.data_req, done64, stall64} !== 3'b000) begin failures++; $display("[TB] FAIL rw_ignored: got %b expected 000", {bus64.data_req, done64, stall64}); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        valid64 = 1'b1; op = 3'b111; addr = 32'h0000_0010; wdata = 32'hDEAD_BEEF;
        next_cycle();
        bus64.data_addr_ok = 1'b1;
        #1;
        checks++; if (bus64.data_be !== 8'h0F) begin failures++; $display("[TB] FAIL bb_sw_be: got %h expected 0f", bus64.data_be); end
        checks++; if (bus64.data_wdata !== 64'hDEADBEEF_DEADBEEF) begin failures++; $display("[TB] FAIL bb_sw_wdata: got %h expected deadbeefdeadbeef", bus64.data_wdata); end
        next_cycle();
        bus64.data_addr_ok = 1'b0; bus64.data_data_ok = 1'b1; bus64.data_rdata = 64'd0;
        #1;
        checks++; if ({done64, stall64} !== 2'b10) begin failures++; $display("[TB] FAIL bb_sw_done: got %b expected 10", {done64, stall64}); end
        next_cycle();
        bus64.data_data_ok = 1'b0; op = 3'b001; addr = 32'h0000_0010;
        #1;
        checks++; if ({stall64, bus64.data_req} !== 2'b10) begin failures++; $display("[TB] FAIL bb_lbu_accept: got %b expected 10", {stall64, bus64.data_req}); end
        next_cycle();
        valid64 = 1'b0; bus64.data_addr_ok = 1'b1;
        #1;
        checks++; if ({bus64.data_req, bus64.data_wr, bus64.data_be} !== {2'b10, 8'h01}) begin failures++; $display("[TB] FAIL bb_lbu_bus: got %b expected 1000000001", {bus64.data_req, bus64.data_wr, bus64.data_be}); end
        next_cycle();
        bus64.data_addr_ok = 1'b0; bus64.data_data_ok = 1'b1; bus64.data_rdata = 64'h0000_00AA_0000_00F0;
        #1;
        checks++; if ({done64, result64} !== {1'b1, 32'h0000_00F0}) begin failures++; $display("[TB] FAIL bb_lbu_result: got %b/%h expected 1/000000f0", done64, result64); end
        next_cycle();
        bus64.data_data_ok = 1'b0;
        next_cycle();
    endtask

    // Sequence the scenarios and print the summary.
    initial begin
        bus32.data_addr_ok = 1'b0; bus32.data_data_ok = 1'b0; bus32.data_rdata = '0;
        bus64.data_addr_ok = 1'b0; bus64.data_data_ok = 1'b0; bus64.data_rdata = '0;
        @(negedge clk);
        test_reset();
        test_lb_sign();
        test_sh_lane64();
        test_misaligned();
        test_flush_drain();
        test_reset_in_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
